// File: rtl/slugtpu_pkg.sv
// -----------------------------------------------------------------------------
// slugtpu_pkg
// Shared definitions for the slugtpu array feeders (input side and weight side).
//   DATA_W        : default operand width per array lane
//   skew_state_e  : feeder FSM states (IDLE, STREAM, DRAIN)
// -----------------------------------------------------------------------------
package slugtpu_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_e;

endpackage

// File: rtl/skew_delay.sv
// -----------------------------------------------------------------------------
// skew_delay
// Holdable shift register of {valid, data} pairs, DEPTH stages long.
// A slot that enters with valid=0 always carries data 0, so downstream
// consumers never see a stale operand in an invalid slot.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset, clears every stage
//   hold_i   : freeze, no stage changes
//   valid_i  : valid bit loaded into stage 0
//   data_i   : data loaded into stage 0 (forced to 0 when valid_i is 0)
//   valid_o  : valid bit of the last stage
//   data_o   : data of the last stage
// -----------------------------------------------------------------------------
module skew_delay
    import slugtpu_pkg::*;
#(
    parameter int DEPTH  = 1,
    parameter int DATA_W = slugtpu_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hold_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!hold_i) begin
            valid_d[0] = valid_i;
            data_d[0]  = valid_i ? data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sysray_input_skew.sv
// -----------------------------------------------------------------------------
// sysray_input_skew
// Input-side feeder for the sysray systolic array. Accepts one row vector per
// handshake and delays lane k by k extra cycles so operands enter the array
// on a diagonal wavefront. Tracks the drain of the final row of a tile and
// pulses done_o when that row's last lane is presented.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   row_data_i  : row vector, lane k at [k*DATA_W +: DATA_W]
//   row_valid_i : row present
//   row_last_i  : row is the last of the tile (qualified by row_valid_i)
//   row_ready_o : row can be accepted this cycle
//   hold_i      : freeze all state and outputs
//   sys_data_o  : skewed operands to the array
//   sys_valid_o : per-lane valid to the array in_valid_input
//   busy_o      : FSM not IDLE
//   done_o      : last row's final lane is being presented (one cycle)
//
// Handshake: a row transfers on a clock edge where row_valid_i && row_ready_o.
// row_ready_o is combinational (low under hold and during DRAIN); the source
// must keep row_data_i/row_last_i stable while row_valid_i is high and ready
// is low. Nothing is accepted between the last row and the return to IDLE.
// -----------------------------------------------------------------------------
module sysray_input_skew
    import slugtpu_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = slugtpu_pkg::DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [LANES*DATA_W-1:0] row_data_i,
    input  logic                    row_valid_i,
    input  logic                    row_last_i,
    output logic                    row_ready_o,
    input  logic                    hold_i,
    output logic [LANES*DATA_W-1:0] sys_data_o,
    output logic [LANES-1:0]        sys_valid_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LANES - 1);

    skew_state_e      state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             accept;

    assign row_ready_o = !hold_i && (state_q != DRAIN);
    assign accept      = row_valid_i && row_ready_o;
    assign busy_o      = (state_q != IDLE);
    // The last row reaches lane LANES-1 exactly when the drain count hits 0;
    // being a function of registers only, the pulse freezes under hold.
    assign done_o      = (state_q == DRAIN) && (drain_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (!hold_i) begin
            unique case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (row_last_i) begin
                            state_d     = DRAIN;
                            drain_cnt_d = CNT_LOAD;
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Lane k gets k+1 stages: stage 0 registers the accept, the extra k
    // stages create the diagonal skew. Non-accept cycles inject bubbles.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        skew_delay #(
            .DEPTH  (k + 1),
            .DATA_W (DATA_W)
        ) u_delay (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .hold_i  (hold_i),
            .valid_i (accept),
            .data_i  (row_data_i[k*DATA_W +: DATA_W]),
            .valid_o (sys_valid_o[k]),
            .data_o  (sys_data_o[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/sysray_input_skew.md
# sysray_input_skew

Upstream feeder for the `sysray` systolic array. It accepts one row vector per handshake, holding one 16-bit operand per array row lane. It delays lane k by k extra cycles so operands enter the array on the diagonal wavefront. It drives the array's per-lane data and `in_valid_input` bits, and tracks end-of-tile draining so the controller knows when the final row has fully entered the array.

## Interface
Parameters:
- `LANES`, default 2: number of array rows/lanes.
- `DATA_W`, default 16: operand width per lane.

Ports:
- `clk_i`  in  1: clock. Single clock domain.
- `rst_ni`  in  1: reset. Asynchronous assert, active-low; all state clears.
- `row_data_i`  in  LANES*DATA_W: row vector. Lane k is bits [k*DATA_W +: DATA_W].
- `row_valid_i`  in  1: row present.
- `row_last_i`  in  1: row is the final row of the tile. Qualified by `row_valid_i`.
- `row_ready_o`  out  1: block can accept a row this cycle.
- `hold_i`  in  1: freeze. All skew state, counters and outputs hold their values.
- `sys_data_o`  out  LANES*DATA_W: skewed operands to the array data inputs.
- `sys_valid_o`  out  LANES: per-lane valid to the array `in_valid_input`.
- `busy_o`  out  1: state is not IDLE.
- `done_o`  out  1: one-cycle pulse when the last row's final lane is presented.

## Operation
- Accept happens when `row_valid_i && row_ready_o`.
- `row_ready_o = !hold_i && (state != DRAIN)`. The output is combinational.
- Lane k has a delay line of k+1 registers. Each register holds a data field and a valid bit. On every non-held edge, stage 0 loads the incoming lane data and valid (the accept bit). Later stages shift.
- Bubbles: a non-held cycle with no accept injects valid=0 and data=0 into every lane. Invalid slots always carry data 0 so array psums never see stale operands.
- FSM states:
  - IDLE: go to STREAM on accept without last. Go to DRAIN on accept with last.
  - STREAM: stay while accepts are non-last or there are bubbles. Go to DRAIN on accept with last.
  - DRAIN: load `drain_cnt` with LANES-1 on entry. Decrement on each non-held edge. When the count is 0 and `done_o` has fired, go to IDLE.
- `done_o` asserts in the cycle where `sys_valid_o[LANES-1]` shows the last row, and is high for exactly one cycle. For LANES=1 there is no drain wait: DRAIN lasts one cycle.
- `hold_i` overrides everything. No register changes, and `done_o` stays at its current value. A pulse that is active when hold asserts stretches for the whole hold.
- A new tile may be accepted on the first cycle after the return to IDLE. There is no back-to-back overlap across tiles.

## Timing
- Reset values: `sys_data_o` = 0, `sys_valid_o` = 0, `done_o` = 0, `busy_o` = 0, state IDLE, `drain_cnt` = 0. `row_ready_o` = 1 if `hold_i` = 0.
- Latency: if a row is accepted at edge E, lane k presents it in the cycle after edge E+k, assuming no holds. Each cycle of hold adds one cycle to this.
- Throughput: one row per cycle in IDLE/STREAM.
- Tile overhead: LANES cycles of `row_ready_o` = 0 after the last accept, for LANES ≥ 2.
- Reset mid-stream or mid-drain: all in-flight rows are discarded. Outputs reach reset values asynchronously. No `done_o` is produced for an aborted tile.
- Simultaneous `hold_i` and `row_valid_i`: no accept, because ready is low. The upstream source must hold its data.
- Accepting `row_last_i` on the first row of a tile goes IDLE→DRAIN directly. This is legal for single-row tiles.

## Structure
- Shared package `slugtpu_pkg`: `DATA_W` default constant and the `skew_state_e` enum {IDLE, STREAM, DRAIN}. Both are reused by the weight-side feeder.
- Sub-module `skew_delay #(DEPTH, DATA_W)`: a holdable shift register of {valid, data} with a clear-on-invalid data field. It is instantiated once per lane with DEPTH=k+1 via a generate loop.
- Top level holds the FSM, `drain_cnt` ($clog2(LANES) bits, minimum 1), and the ready/done logic.

## Test plan
- Reset then idle (LANES=2): no valid input for 10 cycles. Required: `sys_valid_o` = 2'b00, `sys_data_o` = 0, `row_ready_o` = 1, `busy_o` = 0.
- Skew: accept rows {lane0=0x0001, lane1=0x0010} then {0x0002, 0x0020, last}. Required: lane 0 shows 1 then 2 at cycles +1 and +2. Lane 1 shows 0x10 then 0x20 at cycles +2 and +3. `done_o` pulses at +3. `row_ready_o` is low during +2 and +3.
- Bubble: accept A, skip one cycle, accept B(last). Required: a single valid=0, data=0 slot between A and B on both lanes, offset by one cycle on lane 1.
- Hold mid-drain: assert `hold_i` for 3 cycles right after the last accept. Required: all outputs frozen for 3 cycles, and `done_o` arrives exactly 3 cycles late.
- Reset mid-drain: pull `rst_ni` low one cycle after the last accept. Required: outputs are immediately 0, `done_o` is never asserted, and after release the block accepts a new row.
- Single-row tile with LANES=4: one accept with last and data {1,2,3,4}. Required: lane k shows k+1 at cycle +1+k, `done_o` pulses at +4, and the block is back in IDLE at +5.
